// File: rtl/mbist_march_ctrl_pkg.sv
// Shared types and the March C- element table for the MBIST controller.
package mbist_pkg;

   typedef logic [2:0] elem_t;

   typedef enum logic [1:0] {W0, W1, R0, R1} op_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      DRAIN   = 2'd2,
      DONE_ST = 2'd3
   } state_t;

   localparam elem_t LAST_ELEM = 3'd5;

   // M0 (w0) and M5 (r0) have one op per address, the rest two.
   function automatic logic [1:0] elem_nops(elem_t e);
      return (e == 3'd0 || e == LAST_ELEM) ? 2'd1 : 2'd2;
   endfunction

   function automatic logic elem_down(elem_t e);
      return (e == 3'd3 || e == 3'd4);
   endfunction

   function automatic op_t elem_op(elem_t e, logic idx);
      op_t op;
      case (e)
         3'd0:       op = W0;
         3'd1, 3'd3: op = idx ? W1 : R0;
         3'd2, 3'd4: op = idx ? W0 : R1;
         default:    op = R0;
      endcase
      return op;
   endfunction

   function automatic logic op_is_read(op_t op);
      return (op == R0 || op == R1);
   endfunction

   function automatic logic op_bg_one(op_t op);
      return (op == W1 || op == R1);
   endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Single-port SRAM pin bundle (RA1SHD style, active-low controls).
interface mbist_march_ctrl_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              CEN;
   logic              WEN;
   logic              OEN;
   logic [ADDR_W-1:0] A;
   logic [DATA_W-1:0] D;
   logic [DATA_W-1:0] Q;

   modport master (output CEN, WEN, OEN, A, D, input Q);
   modport slave  (input CEN, WEN, OEN, A, D, output Q);
endinterface

// File: rtl/mbist_march_ctrl_addr_gen.sv
// Up/down address counter for one March element; is_last flags the final address.
module mbist_addr_gen #(
   parameter int ADDR_W = 12
) (
   input  logic              CLK,
   input  logic              load,
   input  logic              load_down,
   input  logic              step,
   input  logic              down,
   output logic [ADDR_W-1:0] addr,
   output logic              is_last
);

   always_ff @(posedge CLK) begin
      if (load)
         addr <= load_down ? '1 : '0;
      else if (step)
         addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
   end

   assign is_last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: one SRAM op per cycle, two-stage pipelined read compare.
module mbist_march_ctrl
   import mbist_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   output logic               BUSY,
   output logic               DONE,
   output logic               FAIL,
   output logic [CNT_W-1:0]   FAIL_COUNT,
   output logic [ADDR_W-1:0]  FAIL_ADDR,
   output logic [2:0]         FAIL_ELEM,
   output logic [DATA_W-1:0]  FAIL_BITS,
   mbist_march_ctrl_if.master mem
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      elem_t             elem;
      logic [DATA_W-1:0] exp;
   } cmp_t;

   state_t            state;
   elem_t             elem;
   elem_t             next_elem;
   logic              opi;
   logic [ADDR_W-1:0] addr;
   logic              addr_last;
   op_t               op;
   logic [DATA_W-1:0] bg;
   logic              accept;
   logic              issue;
   logic              addr_done;
   logic              elem_end;
   cmp_t              s1;
   cmp_t              s2;
   logic [DATA_W-1:0] diff;
   logic              mism;

   // Sequencer always rests at (M0, op 0, addr 0) so the first op issues on the START edge.
   assign accept    = START && (state == IDLE || state == DONE_ST);
   assign issue     = accept || (state == RUN);
   assign op        = elem_op(elem, opi);
   assign bg        = op_bg_one(op) ? '1 : '0;
   assign addr_done = ({1'b0, opi} == elem_nops(elem) - 2'd1);
   assign elem_end  = issue && addr_done && addr_last;
   assign next_elem = (elem == LAST_ELEM) ? '0 : elem + 3'd1;

   mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .CLK       (CLK),
      .load      (RST || elem_end),
      .load_down (!RST && elem_down(next_elem)),
      .step      (issue && addr_done),
      .down      (elem_down(elem)),
      .addr      (addr),
      .is_last   (addr_last)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         elem <= '0;
         opi  <= 1'b0;
      end else if (issue) begin
         if (addr_done) begin
            opi <= 1'b0;
            if (addr_last)
               elem <= next_elem;
         end else begin
            opi <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         mem.CEN <= 1'b1;
         mem.WEN <= 1'b1;
         mem.A   <= '0;
         mem.D   <= '0;
         s1      <= '0;
         s2      <= '0;
      end else begin
         case (state)
            IDLE, DONE_ST: if (START) state <= RUN;
            RUN:           if (elem_end && elem == LAST_ELEM) state <= DRAIN;
            DRAIN:         if (!s1.valid) state <= DONE_ST;
            default:       state <= IDLE;
         endcase
         mem.CEN <= !issue;
         mem.WEN <= !(issue && !op_is_read(op));
         if (issue) begin
            mem.A <= addr;
            mem.D <= bg;
         end
         s1.valid <= issue && op_is_read(op);
         s1.addr  <= addr;
         s1.elem  <= elem;
         s1.exp   <= bg;
         s2       <= s1;
      end
   end

   assign mem.OEN = 1'b0;

   // s2 lines up with the Q produced by the memory for that read.
   assign diff = mem.Q ^ s2.exp;
   assign mism = s2.valid && (diff != '0);

   always_ff @(posedge CLK) begin
      if (RST || accept) begin
         FAIL       <= 1'b0;
         FAIL_COUNT <= '0;
         FAIL_ADDR  <= '0;
         FAIL_ELEM  <= '0;
         FAIL_BITS  <= '0;
      end else if (mism) begin
         FAIL <= 1'b1;
         if (FAIL_COUNT != '1)
            FAIL_COUNT <= FAIL_COUNT + CNT_W'(1);
         if (!FAIL) begin
            FAIL_ADDR <= s2.addr;
            FAIL_ELEM <= s2.elem;
            FAIL_BITS <= diff;
         end
      end
   end

   assign BUSY = (state == RUN) || (state == DRAIN);
   assign DONE = (state == DONE_ST);

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- MBIST controller that runs March C- on one RA1SHD-style single-port SRAM (4096x32, active-low CEN/WEN/OEN) through the memory's own port pins.
- Sits between the test access logic (START/status) and the memory, or the memory's fault-injection wrapper.
- Issues one memory operation per cycle and compares read data in a pipeline.
- Reports pass/fail, a saturating fail count and the first failing address, element and bit mask.

Parameters:
- ADDR_W, 12: memory address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32: memory word width; the data backgrounds are all-0 and all-1.
- CNT_W, 16: width of the saturating fail counter.

Ports:
- CLK  in  1  clock; memory and controller share it.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; starts a run when not BUSY.
- BUSY  out  1  high while a run is in progress.
- DONE  out  1  sticky completion flag; cleared by RST or an accepted START.
- FAIL  out  1  sticky; high if any read compare has mismatched.
- FAIL_COUNT  out  CNT_W  number of mismatching reads, saturating at all-ones.
- FAIL_ADDR  out  ADDR_W  address of the first mismatch.
- FAIL_ELEM  out  3  March element (0..5) of the first mismatch.
- FAIL_BITS  out  DATA_W  Q XOR expected data, for the first mismatch.
- CEN  out  1  memory chip enable, active low.
- WEN  out  1  memory write enable, active low.
- OEN  out  1  memory output enable, active low.
- A  out  ADDR_W  memory address.
- D  out  DATA_W  memory write data.
- Q  in  DATA_W  memory read data.

Behaviour:
- Reset values: BUSY=0, DONE=0, FAIL=0, all FAIL_* = 0, CEN=1, WEN=1, OEN=0, A=0, D=0.
- RST in mid-run aborts the run at once: CEN=1 at the next edge and all pending compares are discarded.
- All memory-side outputs are registered.
- March C- elements:
  - M0 up (w0)
  - M1 up (r0, w1)
  - M2 up (r1, w0)
  - M3 down (r0, w1)
  - M4 down (r1, w0)
  - M5 up (r0)
  - "up" runs address 0 to DEPTH-1; "down" runs DEPTH-1 to 0.
  - Inside an element, all operations at one address complete before the address steps.
  - Total operations per run: 10*DEPTH.
- FSM states:
  - IDLE: START=1 goes to RUN at the next edge and clears DONE, FAIL and all FAIL_* outputs.
  - RUN: one operation is driven per cycle, with no bubbles between elements. After the last operation (M5, address DEPTH-1) the FSM goes to DRAIN and drives CEN=1.
  - DRAIN: waits for the last read compare, then goes to DONE_ST.
  - DONE_ST: DONE=1, BUSY=0. START=1 restarts the run exactly as from IDLE.
- START while BUSY is ignored.
- Operation encoding:
  - Write: CEN=0, WEN=0, D=background (all 0s or all 1s).
  - Read: CEN=0, WEN=1, D is don't-care.
  - OEN is held at 0 at all times.
- Timing, with the START edge as edge 0:
  - BUSY rises at edge 1.
  - Operation i is driven at edge 1+i; the memory samples it at edge 2+i.
  - Q is compared at edge 3+i.
  - DONE rises and BUSY falls at edge 10*DEPTH+2.
- Compare pipeline: each read carries {valid, addr, elem, expected} through two register stages. The compare uses Q as it stands before edge 3+i.
- On a mismatch:
  - FAIL is set.
  - FAIL_COUNT increments, holding at 2**CNT_W-1 once reached.
  - The FAIL_ADDR/ELEM/BITS fields are captured only if FAIL was 0 before this compare.
  - The run continues to completion.
- Counter width rules: the address counter is ADDR_W bits. The last address in an up element is all-ones and in a down element is 0; the counter must never wrap into the next element.

Decomposition:
- Package mbist_pkg holds:
  - the element index typedef (3 bits);
  - the op enum: W0, W1, R0, R1;
  - the per-element constants: number of ops, op list, direction;
  - the FSM state enum.
- One sub-module, mbist_addr_gen:
  - ADDR_W up/down counter with load-start, step and an is_last flag;
  - the direction is selected per element.

Test Plan:
- Fault-free memory, ADDR_W=4: START pulse -> BUSY at edge 1, DONE at edge 162, FAIL=0, FAIL_COUNT=0; the bus trace shows exactly 160 operations in March C- order.
- RA1SHD_f stuck-at-0 at address 0x7FB, bit 28, full depth -> FAIL=1, FAIL_COUNT=2, FAIL_ADDR=0x7FB, FAIL_ELEM=2, FAIL_BITS=0x10000000, DONE at edge 40962.
- Same fault with sa1 -> FAIL_COUNT=3, FAIL_ADDR=0x7FB, FAIL_ELEM=1, FAIL_BITS=0x10000000.
- RST asserted at edge 50 of an ADDR_W=4 run -> next edge: CEN=1, BUSY=0, FAIL=0. A new START gives a clean full run, DONE at edge 162 relative to that START.
- START pulses at edges 5 and 100 during a run -> both ignored; DONE timing is unchanged. START in DONE_ST -> DONE cleared and the run restarts.
- CNT_W=2, fault model failing every read at address 3 (ADDR_W=4) -> FAIL_COUNT saturates at 3; the first-fail fields stay at elem 1, addr 3.
